// File: rtl/div_seq_pkg.sv
// Shared definitions for the sequential divider: FSM state encoding,
// handshake level names and the EX-stage aluop codes that select it.
package div_seq_pkg;

  // Divider FSM states
  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  // Result handshake levels
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  // Request levels driven by EX on start_i
  localparam logic DivStart = 1'b1;
  localparam logic DivStop  = 1'b0;

  // aluop codes that route an instruction to this block
  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

endpackage

// File: rtl/div_seq_iter.sv
// One restoring-division step: shift {remainder, dividend} left by one,
// trial-subtract the divisor from the widened remainder and shift the
// resulting quotient bit into the vacated low end of the dividend half.
module div_seq_iter #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   divisor_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Remainder is kept below the divisor, so the shifted value fits in
  // WIDTH+1 bits and bit WIDTH of the difference is a clean borrow flag.
  always_comb begin
    shifted = acc_i[2*WIDTH-1:WIDTH-1];
    diff    = shifted - {1'b0, divisor_i};
    if (!diff[WIDTH]) begin
      acc_o = {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
    end else begin
      acc_o = {shifted[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle radix-2 restoring divider serving DIV/DIVU beside EX.
// Operands are captured as magnitudes, WIDTH iterations run one per
// cycle, and signs are restored when the result is registered.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stallreq_o
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  div_state_e         state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [2*WIDTH-1:0] acc_reg;      // {partial remainder, dividend/quotient}
  logic [WIDTH-1:0]   divisor_reg;
  logic               neg_q_reg;
  logic               neg_r_reg;
  logic [2*WIDTH-1:0] result_reg;
  logic               ready_reg;

  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   op1_abs;
  logic [WIDTH-1:0]   op2_abs;
  logic [WIDTH-1:0]   q_fix;
  logic [WIDTH-1:0]   r_fix;

  div_seq_iter #(.WIDTH(WIDTH)) u_iter (
    .acc_i     (acc_reg),
    .divisor_i (divisor_reg),
    .acc_o     (acc_next)
  );

  // Operand magnitudes at capture and sign restoration of the final step;
  // the most negative value maps onto itself, which is the wanted result.
  always_comb begin
    op1_abs = (signed_div_i && opdata1_i[WIDTH-1]) ? (~opdata1_i + WIDTH'(1)) : opdata1_i;
    op2_abs = (signed_div_i && opdata2_i[WIDTH-1]) ? (~opdata2_i + WIDTH'(1)) : opdata2_i;
    q_fix   = neg_q_reg ? (~acc_next[WIDTH-1:0] + WIDTH'(1)) : acc_next[WIDTH-1:0];
    r_fix   = neg_r_reg ? (~acc_next[2*WIDTH-1:WIDTH] + WIDTH'(1)) : acc_next[2*WIDTH-1:WIDTH];
  end

  // Sequencer: accept, iterate, present the result until EX releases start_i.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= DivFree;
      cnt_reg     <= '0;
      acc_reg     <= '0;
      divisor_reg <= '0;
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
      result_reg  <= '0;
      ready_reg   <= DivResultNotReady;
    end else begin
      case (state_reg)
        DivFree: begin
          result_reg <= '0;
          ready_reg  <= DivResultNotReady;
          if (start_i == DivStart && !annul_i) begin
            if (opdata2_i == '0) begin
              state_reg <= DivByZero;
            end else begin
              state_reg   <= DivOn;
              cnt_reg     <= '0;
              acc_reg     <= {{WIDTH{1'b0}}, op1_abs};
              divisor_reg <= op2_abs;
              neg_q_reg   <= signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
              neg_r_reg   <= signed_div_i & opdata1_i[WIDTH-1];
            end
          end
        end
        DivByZero: begin
          if (annul_i) begin
            state_reg <= DivFree;
            ready_reg <= DivResultNotReady;
          end else begin
            state_reg  <= DivEnd;
            result_reg <= '0;
            ready_reg  <= DivResultReady;
          end
        end
        DivOn: begin
          if (annul_i) begin
            state_reg <= DivFree;
            ready_reg <= DivResultNotReady;
          end else begin
            acc_reg <= acc_next;
            cnt_reg <= cnt_reg + CNT_W'(1);
            if (cnt_reg == LAST_ITER) begin
              state_reg  <= DivEnd;
              result_reg <= {r_fix, q_fix};
              ready_reg  <= DivResultReady;
            end
          end
        end
        DivEnd: begin
          if (annul_i || start_i == DivStop) begin
            state_reg  <= DivFree;
            result_reg <= '0;
            ready_reg  <= DivResultNotReady;
          end
        end
        default: state_reg <= DivFree;
      endcase
    end
  end

  assign result_o   = result_reg;
  assign ready_o    = ready_reg;
  assign stallreq_o = start_i & ~ready_reg;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed cases from the plan plus
// randomized divisions compared against plain-arithmetic reference results.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stallreq_o;

  int n_checks = 0;
  int n_errors = 0;

  div_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .stallreq_o   (stallreq_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: 64-bit integer arithmetic truncating toward zero; divide by
  // zero yields zero; results wrapped to 32 bits.
  function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // One full transaction from the start cycle to release. end_annul ends it
  // by annulling in END instead of dropping start_i.
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input int hold, input bit end_annul);
    logic [63:0] exp;
    int          lat;
    int          cyc;
    bit          stall_ok;
    bit          hold_ok;
    exp = model(sgn, a, b);
    lat = (b == 32'd0) ? 2 : 33;
    @(negedge clk);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    #1;
    stall_ok = (stallreq_o === 1'b1) && (ready_o === 1'b0);
    @(negedge clk);
    cyc = 1;
    // operands must not be re-sampled after acceptance
    opdata1_i    = $urandom;
    opdata2_i    = $urandom;
    signed_div_i = 1'($urandom);
    while (ready_o !== 1'b1 && cyc < 80) begin
      if (stallreq_o !== 1'b1) stall_ok = 0;
      @(negedge clk);
      cyc++;
    end
    $display("div %s sgn=%0d a=%h b=%h -> result=%h ready_cycle=%0d", tag, sgn, a, b, result_o, cyc);
    check({tag, "_latency"}, 64'(cyc), 64'(lat));
    check({tag, "_result"}, result_o, exp);
    check({tag, "_stall_at_ready"}, 64'(stallreq_o), 64'd0);
    check({tag, "_stall_before"}, 64'(stall_ok), 64'd1);
    hold_ok = 1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (ready_o !== 1'b1 || result_o !== exp || stallreq_o !== 1'b0) hold_ok = 0;
    end
    if (hold > 0) check({tag, "_hold"}, 64'(hold_ok), 64'd1);
    if (end_annul) begin
      annul_i = 1'b1;
      @(negedge clk);
      check({tag, "_end_annul_ready"}, 64'(ready_o), 64'd0);
      check({tag, "_end_annul_result"}, result_o, 64'd0);
      annul_i = 1'b0;
      start_i = 1'b0;
      @(negedge clk);
    end else begin
      start_i = 1'b0;
      @(negedge clk);
      check({tag, "_release_ready"}, 64'(ready_o), 64'd0);
      check({tag, "_release_result"}, result_o, 64'd0);
    end
  endtask

  initial begin
    int  cyc;
    bit  any_ready;
    logic [31:0] ra, rb;
    logic        rs;

    rst = 1'b1;
    start_i = 1'b0;
    annul_i = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i = '0;
    opdata2_i = '0;
    repeat (3) @(negedge clk);
    check("reset_ready", 64'(ready_o), 64'd0);
    check("reset_result", result_o, 64'd0);
    check("reset_stall", 64'(stallreq_o), 64'd0);
    rst = 1'b0;

    // Directed cases
    run_div("u100_7", 1'b0, 32'd100, 32'd7, 0, 0);
    run_div("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 0, 0);
    run_div("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 0, 0);
    run_div("divzero", 1'b0, 32'd5, 32'd0, 0, 0);
    run_div("hold5", 1'b0, 32'd12345, 32'd99, 5, 0);
    run_div("s_corner", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    run_div("u_corner", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    run_div("end_annul", 1'b1, 32'hFFFF_FF00, 32'd3, 0, 1);
    run_div("u_max", 1'b0, 32'hFFFF_FFFF, 32'd1, 0, 0);

    // Annul in the middle of the iterations
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i = 32'd50;
    opdata2_i = 32'd6;
    start_i = 1'b1;
    any_ready = 0;
    for (cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (ready_o === 1'b1) any_ready = 1;
    end
    annul_i = 1'b1;
    @(negedge clk);
    check("annul_ready_c11", 64'(ready_o), 64'd0);
    annul_i = 1'b0;
    start_i = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (ready_o === 1'b1) any_ready = 1;
    end
    $display("annul mid-run done");
    check("annul_no_ready", 64'(any_ready), 64'd0);
    run_div("after_annul", 1'b0, 32'd9, 32'd3, 0, 0);

    // Reset in the middle of the iterations
    @(negedge clk);
    signed_div_i = 1'b1;
    opdata1_i = 32'd1000;
    opdata2_i = 32'hFFFF_FFFD;
    start_i = 1'b1;
    repeat (15) @(negedge clk);
    rst = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    check("midrst_ready", 64'(ready_o), 64'd0);
    check("midrst_result", result_o, 64'd0);
    check("midrst_stall", 64'(stallreq_o), 64'd0);
    rst = 1'b0;
    any_ready = 0;
    repeat (40) begin
      @(negedge clk);
      if (ready_o === 1'b1) any_ready = 1;
    end
    $display("reset mid-run done");
    check("midrst_no_ready", 64'(any_ready), 64'd0);

    // Randomized divisions with occasional zero and extreme operands
    for (int n = 0; n < 20; n++) begin
      rs = 1'($urandom);
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = $urandom_range(1, 15);
        2: begin rb = 32'hFFFF_FFFF; ra = 32'h8000_0000; end
        3: ra = $urandom_range(0, 100);
        default: ;
      endcase
      run_div($sformatf("rand%0d", n), rs, ra, rb, $urandom_range(0, 2), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
